// File: rtl/oldland_prefetch.sv
// rtl/oldland_prefetch.sv - instruction prefetch with one outstanding bus request and an in-order queue.
// Define OLDLAND_PREFETCH_FIFO_EN for a 4-entry queue; otherwise a single holding register.
module oldland_prefetch #(
  parameter logic [31:0] RESET_PC  = 32'h00000000,
  parameter logic [31:0] NOP_INSTR = 32'h00000000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        i_access,
  output logic [31:0] i_addr,
  input  logic [31:0] i_data,
  input  logic        i_ack,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_pc,
  output logic [31:0] instr,
  output logic [31:0] pc_plus_4,
  output logic        instr_valid
);

`ifdef OLDLAND_PREFETCH_FIFO_EN
  localparam int DEPTH = 4;
  localparam int CW    = 3;
`else
  localparam int DEPTH = 1;
  localparam int CW    = 1;
`endif

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DISCARD} state_t;

  state_t          r_state;
  logic            r_access;
  logic [31:0]     r_req_addr;
  logic [31:0]     r_fetch_pc;
  logic [CW-1:0]   r_count;

  logic [31:0]     w_q_instr [DEPTH];
  logic [31:0]     w_q_pc4   [DEPTH];
  logic            w_valid;
  logic            w_pop;
  logic            w_push;
  logic [31:0]     w_req_next;
  logic [31:0]     w_branch_pc;
  logic [CW-1:0]   w_count_pp;
  logic [CW-1:0]   w_wr_idx;
  logic            w_room;
  logic            w_room_pp;

  assign w_valid     = (r_count != '0);
  assign w_pop       = w_valid & ~stall & ~branch_taken;
  assign w_push      = (r_state == S_REQ) & i_ack & ~branch_taken;
  assign w_req_next  = r_req_addr + 32'd4;
  assign w_branch_pc = branch_pc & 32'hFFFF_FFFC;
  assign w_count_pp  = r_count + CW'(w_push) - CW'(w_pop);
  // A simultaneous pop shifts the queue down, so the write slot moves down with it.
  assign w_wr_idx    = r_count - CW'(w_pop);
  assign w_room      = (r_count < CW'(DEPTH));
  assign w_room_pp   = (w_count_pp < CW'(DEPTH));

  assign i_access    = r_access;
  assign i_addr      = r_req_addr;
  assign instr_valid = w_valid;
  assign instr       = w_valid ? w_q_instr[0] : NOP_INSTR;
  assign pc_plus_4   = w_valid ? w_q_pc4[0]   : 32'h0;

  for (genvar g = 0; g < DEPTH; g++) begin : g_q
    logic [31:0] r_instr;
    logic [31:0] r_pc4;
    logic [31:0] w_next_instr;
    logic [31:0] w_next_pc4;

    if (g < DEPTH - 1) begin : g_mid
      assign w_next_instr = w_q_instr[g+1];
      assign w_next_pc4   = w_q_pc4[g+1];
    end else begin : g_last
      assign w_next_instr = 32'h0;
      assign w_next_pc4   = 32'h0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_instr <= 32'h0;
        r_pc4   <= 32'h0;
      end else if (w_push && (w_wr_idx == CW'(g))) begin
        r_instr <= i_data;
        r_pc4   <= w_req_next;
      end else if (w_pop) begin
        r_instr <= w_next_instr;
        r_pc4   <= w_next_pc4;
      end
    end

    assign w_q_instr[g] = r_instr;
    assign w_q_pc4[g]   = r_pc4;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_access   <= 1'b0;
      r_req_addr <= RESET_PC;
      r_fetch_pc <= RESET_PC;
      r_count    <= '0;
    end else begin
      r_count <= branch_taken ? '0 : w_count_pp;
      case (r_state)
        S_IDLE: begin
          if (branch_taken) begin
            r_fetch_pc <= w_branch_pc;
          end else if (w_room) begin
            r_state    <= S_REQ;
            r_access   <= 1'b1;
            r_req_addr <= r_fetch_pc;
          end
        end
        S_REQ: begin
          if (i_ack) begin
            if (branch_taken) begin
              r_fetch_pc <= w_branch_pc;
              r_state    <= S_IDLE;
              r_access   <= 1'b0;
            end else begin
              r_fetch_pc <= w_req_next;
              if (w_room_pp) begin
                r_req_addr <= w_req_next;
              end else begin
                r_state  <= S_IDLE;
                r_access <= 1'b0;
              end
            end
          end else if (branch_taken) begin
            r_fetch_pc <= w_branch_pc;
            r_state    <= S_DISCARD;
          end
        end
        S_DISCARD: begin
          // The stale request must still complete on the bus before a new one is issued.
          if (branch_taken) r_fetch_pc <= w_branch_pc;
          if (i_ack) begin
            r_state  <= S_IDLE;
            r_access <= 1'b0;
          end
        end
        default: begin
          r_state  <= S_IDLE;
          r_access <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/oldland_prefetch.md
OLDLAND_PREFETCH -- requirements
Module: oldland_prefetch

Interface
REQ-001 The block SHALL take parameter RESET_PC, default 32'h00000000, the first fetch address after reset.
REQ-002 The block SHALL take parameter NOP_INSTR, default 32'h00000000, the word driven on instr when no instruction is valid.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 i_access  output  1  instruction bus request, held until i_ack.
REQ-006 i_addr  output  32  instruction bus word address, bits [1:0] always 2'b00.
REQ-007 i_data  input  32  instruction bus read data, valid only with i_ack.
REQ-008 i_ack  input  1  one-cycle bus completion strobe.
REQ-009 stall  input  1  downstream (decode) cannot accept this cycle.
REQ-010 branch_taken  input  1  one-cycle redirect strobe.
REQ-011 branch_pc  input  32  redirect target, sampled with branch_taken, bits [1:0] ignored.
REQ-012 instr  output  32  head-of-queue instruction word to decode; NOP_INSTR when instr_valid=0.
REQ-013 pc_plus_4  output  32  address of instr plus 4; 32'h0 when instr_valid=0.
REQ-014 instr_valid  output  1  instr/pc_plus_4 hold a fetched instruction.

Function
REQ-015 The block SHALL hold fetched {instr, pc_plus_4} pairs in an in-order queue of DEPTH entries (DEPTH set by REQ-030/031); instr, pc_plus_4 and instr_valid SHALL be driven combinationally from the queue head.
REQ-016 The head SHALL be consumed (popped) on a rising edge where instr_valid=1 and stall=0 and branch_taken=0.
REQ-017 The block SHALL implement states IDLE, REQ, DISCARD, with at most one bus request outstanding.
REQ-018 IDLE: i_access=0; transition to REQ with req_addr<=fetch_pc when queue count < DEPTH and branch_taken=0.
REQ-019 REQ: i_access=1, i_addr=req_addr held stable until i_ack; on i_ack, push {i_data, req_addr+4} and set fetch_pc<=req_addr+4.
REQ-020 REQ with i_ack: remain in REQ with req_addr<=req_addr+4 if post-push/post-pop count < DEPTH, else go to IDLE.
REQ-021 REQ with branch_taken and no i_ack: go to DISCARD, i_addr unchanged; with simultaneous i_ack: drop i_data, go to IDLE.
REQ-022 DISCARD: i_access=1 on the old address; on i_ack drop i_data, go to IDLE; no queue push.
REQ-023 branch_taken SHALL, in any state, set fetch_pc<=branch_pc with bits [1:0] forced to 2'b00, and flush the queue (count<=0) on the same edge; flush SHALL take priority over push and pop.
REQ-024 branch_taken while in DISCARD SHALL update fetch_pc again and remain in DISCARD.
REQ-025 Simultaneous push and pop SHALL leave count unchanged; push into a full queue SHALL never occur.
REQ-026 fetch_pc and req_addr SHALL wrap modulo 2^32 (32'hFFFFFFFC + 4 = 32'h00000000).
REQ-027 Minimum latency: redirect edge -> i_access=1 for branch_pc one cycle later (IDLE->REQ); i_ack edge -> instr_valid=1 combinationally after that edge.

Reset
REQ-028 While rst_n=0: state=IDLE, fetch_pc=RESET_PC, req_addr=RESET_PC, count=0, i_access=0, instr=NOP_INSTR, pc_plus_4=32'h0, instr_valid=0.
REQ-029 Reset asserted mid-request SHALL abandon the request; any i_ack arriving after release while in IDLE SHALL be ignored.

Configuration
REQ-030 With macro OLDLAND_PREFETCH_FIFO_EN defined, DEPTH SHALL be 4 and count SHALL be 3 bits.
REQ-031 Without OLDLAND_PREFETCH_FIFO_EN, DEPTH SHALL be 1 (single holding register); all other requirements unchanged.

Verification
REQ-032 Reset release, RESET_PC=0, i_ack one cycle after each i_access, stall=0 -> i_addr sequence 0,4,8,...; instr/pc_plus_4 pairs match i_data with pc_plus_4=4,8,12.
REQ-033 FIFO_EN, stall=1 held -> exactly 4 acks accepted, i_access drops to 0; release stall -> 4 instructions drain in order, one per cycle.
REQ-034 branch_taken with branch_pc=32'h100 while REQ to 32'h8 awaits ack (ack 3 cycles later) -> DISCARD, data at 8 never appears; next i_addr=32'h100.
REQ-035 branch_taken coincident with i_ack and pop, queue holding 2 entries -> instr_valid=0 next cycle, acked data dropped, fetch resumes at branch_pc.
REQ-036 RESET_PC=32'hFFFFFFFC, two fetches -> i_addr 32'hFFFFFFFC then 32'h0; pc_plus_4 of first = 32'h0.
REQ-037 rst_n pulsed low during REQ -> i_access=0 immediately; after release, fetch restarts at RESET_PC with queue empty.
